// File: rtl/mac_pool_kernel.sv
// Single-lane MAC / max-pool element: accumulates data*weight on a pre-scaled
// bias (or tracks the signed maximum) and requantises one result per job.
module mac_pool_kernel #(
  parameter int DATA_W     = 8,
  parameter int WEIGHT_W   = 8,
  parameter int BIAS_W     = 8,
  parameter int ACC_W      = 24,
  parameter int BIAS_SHIFT = 4,
  parameter int OUT_SHIFT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [BIAS_W-1:0]   bias,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [WEIGHT_W-1:0] in_weight,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic                out_sat,
  output logic [1:0]          dbg_state
);
  localparam int PROD_W = DATA_W + WEIGHT_W;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]       RES_MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       RES_MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    pool_q;
  logic                    signed_sat_q;
  logic                    sat_q;
  logic [DATA_W-1:0]       out_result_q;
  logic                    out_sat_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    sum_wide;
  logic                     mac_ovf;
  logic signed [ACC_W-1:0]  mac_d;
  logic signed [ACC_W-1:0]  data_ext;
  logic signed [ACC_W-1:0]  bias_init;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        res_d;
  logic                     res_sat;

  always_comb begin
    prod      = $signed(in_data) * $signed(in_weight);
    // One guard bit above the accumulator exposes overflow of the running sum.
    sum_wide  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    mac_ovf   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    mac_d     = sum_wide[ACC_W-1:0];
    if (mac_ovf) mac_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    data_ext  = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    bias_init = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} << BIAS_SHIFT;
    shifted   = acc_q >>> OUT_SHIFT;

    res_d   = shifted[DATA_W-1:0];
    res_sat = 1'b0;
    if (pool_q) begin
      res_d = acc_q[DATA_W-1:0];
    end else if (shifted > RES_MAX) begin
      res_d   = RES_MAX_D;
      res_sat = 1'b1;
    end else if (!signed_sat_q && shifted[ACC_W-1]) begin
      res_d = '0;
    end else if (shifted < RES_MIN) begin
      res_d   = RES_MIN_D;
      res_sat = 1'b1;
    end
  end

  // Input beat transfers on an edge where in_valid && in_ready (ACCUM only);
  // the result transfers on an edge where out_valid && out_ready (DONE only).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      pool_q       <= 1'b0;
      signed_sat_q <= 1'b0;
      sat_q        <= 1'b0;
      out_result_q <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pool_q       <= (mode == 2'd1);
            signed_sat_q <= (mode == 2'd2);
            sat_q        <= 1'b0;
            acc_q        <= (mode == 2'd1) ? RES_MIN : bias_init;
            state_q      <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            if (pool_q) begin
              if (data_ext > acc_q) acc_q <= data_ext;
            end else begin
              acc_q <= mac_d;
              if (mac_ovf) sat_q <= 1'b1;
            end
            if (in_last) state_q <= S_FINAL;
          end
        end
        S_FINAL: begin
          out_result_q <= res_d;
          out_sat_q    <= sat_q | res_sat;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign in_ready   = (state_q == S_ACCUM);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = out_result_q;
  assign out_sat    = out_sat_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_mac_pool_kernel.sv
// Self-checking bench for mac_pool_kernel: directed plan vectors plus random
// jobs scored against an arithmetic reference model.
module tb_mac_pool_kernel;
  localparam int DATA_W     = 8;
  localparam int WEIGHT_W   = 8;
  localparam int BIAS_W     = 8;
  localparam int ACC_W      = 24;
  localparam int BIAS_SHIFT = 4;
  localparam int OUT_SHIFT  = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [1:0]          mode = '0;
  logic [BIAS_W-1:0]   bias = '0;
  logic                busy;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data = '0;
  logic [WEIGHT_W-1:0] in_weight = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DATA_W-1:0]   out_result;
  logic                out_sat;
  logic [1:0]          dbg_state;

  int checks = 0;
  int errors = 0;
  int job_d[$];
  int job_w[$];
  logic [DATA_W:0] exp_q[$];

  always #5 clk = ~clk;

  mac_pool_kernel #(
    .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .BIAS_W(BIAS_W),
    .ACC_W(ACC_W), .BIAS_SHIFT(BIAS_SHIFT), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bias(bias),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_sat(out_sat),
    .dbg_state(dbg_state)
  );

  // Reference model: plain integer arithmetic over the queued job, returns {sat, result}.
  function automatic logic [DATA_W:0] model(input int m, input int b);
    longint acc, s, amax, amin;
    int rmax, rmin, res;
    bit sat;
    logic [DATA_W-1:0] r8;
    amax = (longint'(1) << (ACC_W-1)) - 1;
    amin = -(longint'(1) << (ACC_W-1));
    rmax = (1 << (DATA_W-1)) - 1;
    rmin = -(1 << (DATA_W-1));
    sat  = 1'b0;
    acc  = (m == 1) ? longint'(rmin) : longint'(b) * (longint'(1) << BIAS_SHIFT);
    foreach (job_d[i]) begin
      if (m == 1) begin
        if (job_d[i] > acc) acc = job_d[i];
      end else begin
        acc = acc + longint'(job_d[i]) * longint'(job_w[i]);
        if (acc > amax) begin acc = amax; sat = 1'b1; end
        if (acc < amin) begin acc = amin; sat = 1'b1; end
      end
    end
    if (m == 1) begin
      res = int'(acc);
    end else begin
      s = (acc >= 0) ? acc / (1 << OUT_SHIFT) : -((-acc + (1 << OUT_SHIFT) - 1) / (1 << OUT_SHIFT));
      if (s > rmax) begin res = rmax; sat = 1'b1; end
      else if (s < 0 && m != 2) res = 0;
      else if (s < rmin) begin res = rmin; sat = 1'b1; end
      else res = int'(s);
    end
    r8 = DATA_W'(res);
    return {sat, r8};
  endfunction

  // Drives one job from job_d/job_w. proto bits: start seen, no timeout,
  // FINAL bubble seen, 2-cycle latency + stable hold, back to IDLE.
  task automatic run_job(input int m, input int b, input int gap_pct, input int hold,
                         input bit poke, output logic [DATA_W:0] obs, output logic [4:0] proto);
    bit rdy, tmo, hold_ok;
    int to, lat, gaps;
    proto = '0;
    tmo = 1'b0;
    mode = 2'(m); bias = BIAS_W'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    proto[0] = busy && in_ready;
    foreach (job_d[i]) begin
      gaps = ($urandom_range(0, 99) < gap_pct) ? $urandom_range(1, 3) : 0;
      repeat (gaps) begin
        in_valid = 1'b0; in_data = DATA_W'($urandom); in_last = 1'($urandom);
        if (poke) begin start = 1'($urandom); mode = 2'($urandom); bias = BIAS_W'($urandom); end
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = DATA_W'(job_d[i]); in_weight = WEIGHT_W'(job_w[i]);
      in_last = (i == job_d.size() - 1);
      if (poke) begin start = 1'($urandom); mode = 2'($urandom); bias = BIAS_W'($urandom); end
      to = 0;
      do begin
        rdy = in_ready;
        @(posedge clk); #1;
        to++;
      end while (!rdy && to < 50);
      if (!rdy) tmo = 1'b1;
      in_valid = 1'b0; in_last = 1'b0;
    end
    proto[1] = !tmo;
    proto[2] = busy && !in_ready && !out_valid;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = {out_sat, out_result};
    hold_ok = 1'b1;
    repeat (hold) begin
      if (poke) begin start = 1'($urandom); mode = 2'($urandom); bias = BIAS_W'($urandom); end
      @(posedge clk); #1;
      if (!out_valid || {out_sat, out_result} !== obs) hold_ok = 1'b0;
    end
    proto[3] = (lat == 2) && hold_ok;
    start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    proto[4] = !busy && !out_valid && !in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready, out_valid, out_sat, out_result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b ov=%b sat=%b res=%h, want all 0",
               busy, in_ready, out_valid, out_sat, out_result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b rdy=%b, want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_mac_relu();
    logic [DATA_W:0] obs, exp_v;
    logic [4:0] proto;
    job_d = '{3, -2}; job_w = '{4, 5};
    exp_q.push_back(model(0, 2));
    run_job(0, 2, 0, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || exp_v !== 9'h002) begin errors++; $display("FAIL relu_plan1: got %h want %h", obs, exp_v); end
    checks++;
    if (proto !== 5'b11111) begin errors++; $display("FAIL relu_plan1_timing: got %b want 11111", proto); end
    job_d = '{-8}; job_w = '{8};
    exp_q.push_back(model(0, 0));
    run_job(0, 0, 0, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || proto !== 5'b11111) begin errors++; $display("FAIL relu_negative: got %h/%b want %h/11111", obs, proto, exp_v); end
    job_d = {}; job_w = {};
    repeat (16) begin job_d.push_back(127); job_w.push_back(127); end
    exp_q.push_back(model(3, 0));
    run_job(3, 0, 20, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || exp_v !== 9'h17F) begin errors++; $display("FAIL relu_clamp_mode3: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_mac_signed();
    logic [DATA_W:0] obs, exp_v;
    logic [4:0] proto;
    job_d = '{-8}; job_w = '{8};
    exp_q.push_back(model(2, 0));
    run_job(2, 0, 0, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || exp_v !== 9'h0FC) begin errors++; $display("FAIL signed_neg: got %h want %h", obs, exp_v); end
    job_d = '{-128}; job_w = '{127};
    exp_q.push_back(model(2, 0));
    run_job(2, 0, 0, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || exp_v !== 9'h180) begin errors++; $display("FAIL signed_clamp_low: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_acc_sat();
    logic [DATA_W:0] obs, exp_v;
    logic [4:0] proto;
    job_d = {}; job_w = {};
    repeat (512) begin job_d.push_back(-128); job_w.push_back(-128); end
    exp_q.push_back(model(2, 0));
    run_job(2, 0, 0, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || exp_v !== 9'h17F) begin errors++; $display("FAIL acc_sat_pos: got %h want %h", obs, exp_v); end
    job_d = {}; job_w = {};
    repeat (512) begin job_d.push_back(-128); job_w.push_back(127); end
    for (int m = 0; m < 3; m += 2) begin
      exp_q.push_back(model(m, -128));
      run_job(m, -128, 0, 0, 1'b0, obs, proto);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v || proto !== 5'b11111) begin
        errors++; $display("FAIL acc_sat_neg_mode%0d: got %h/%b want %h/11111", m, obs, proto, exp_v);
      end
    end
  endtask

  task automatic test_pool();
    logic [DATA_W:0] obs, exp_v;
    logic [4:0] proto;
    job_d = '{5, -3, 100, -128};
    job_w = {};
    repeat (4) job_w.push_back($urandom_range(0, 255) - 128);
    exp_q.push_back(model(1, 7));
    run_job(1, 7, 0, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || exp_v !== 9'h064) begin errors++; $display("FAIL pool_max: got %h want %h", obs, exp_v); end
    job_d = '{-7, -2, -9}; job_w = '{1, -1, 3};
    exp_q.push_back(model(1, 0));
    run_job(1, 0, 50, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || exp_v !== 9'h0FE) begin errors++; $display("FAIL pool_all_neg: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_protocol();
    logic [DATA_W:0] obs, exp_v;
    logic [4:0] proto;
    job_d = '{3, -2}; job_w = '{4, 5};
    exp_q.push_back(model(0, 2));
    run_job(0, 2, 60, 5, 1'b1, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || proto !== 5'b11111) begin errors++; $display("FAIL hold_and_poke: got %h/%b want %h/11111", obs, proto, exp_v); end
    // Abort a job mid-ACCUM with reset; out_result still holds the previous 2.
    mode = 2'd0; bias = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'd100; in_weight = 8'd100; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, out_sat, out_result} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b rdy=%b ov=%b sat=%b res=%h, want all 0",
               busy, in_ready, out_valid, out_sat, out_result);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    job_d = '{3, -2}; job_w = '{4, 5};
    exp_q.push_back(model(0, 2));
    run_job(0, 2, 0, 0, 1'b0, obs, proto);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || proto !== 5'b11111) begin errors++; $display("FAIL after_reset_job: got %h/%b want %h/11111", obs, proto, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W:0] obs, exp_v;
    logic [4:0] proto;
    int m, b, n;
    for (int j = 0; j < 40; j++) begin
      m = $urandom_range(0, 3);
      b = $urandom_range(0, 255) - 128;
      n = $urandom_range(1, 12);
      job_d = {}; job_w = {};
      repeat (n) begin
        job_d.push_back($urandom_range(0, 255) - 128);
        job_w.push_back($urandom_range(0, 255) - 128);
      end
      exp_q.push_back(model(m, b));
      run_job(m, b, $urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom), obs, proto);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_job%0d mode%0d: got %h want %h", j, m, obs, exp_v); end
      checks++;
      if (proto !== 5'b11111) begin errors++; $display("FAIL random_job%0d_timing: got %b want 11111", j, proto); end
    end
  endtask

  initial begin
    test_reset();
    test_mac_relu();
    test_mac_signed();
    test_acc_sat();
    test_pool();
    test_protocol();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_pool_kernel.md
# mac_pool_kernel

Parametrised single-lane compute element for the MNIST inference datapath: accumulates a stream of signed data×weight products on top of a pre-scaled bias, then requantises with ReLU or signed saturation. In pool mode it returns the signed maximum of the data stream. Jobs are framed by a start pulse and an in_last beat, with valid/ready handshakes on input and output. It sits between the weight/feature-map sequencer and the layer output buffer.

## Interface
- DATA_W, 8: data/result width, signed two's complement
- WEIGHT_W, 8: weight width, signed
- BIAS_W, 8: bias width, signed
- ACC_W, 24: accumulator width; must be ≥ DATA_W+WEIGHT_W+1
- BIAS_SHIFT, 4: left shift applied to bias before accumulation
- OUT_SHIFT, 4: arithmetic right shift applied to accumulator at requantisation
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin job; honoured only in IDLE
- mode  in  2  latched at start: 0 MAC+ReLU, 1 max-pool, 2 MAC signed-saturate, 3 same as 0
- bias  in  BIAS_W  latched at start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  high only in ACCUM
- in_data  in  DATA_W  signed data
- in_weight  in  WEIGHT_W  signed weight; ignored in mode 1
- in_last  in  1  marks final beat of job
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_result  out  DATA_W  signed result
- out_sat  out  1  saturation occurred in this job (valid with out_valid)

## Operation
- States: IDLE, ACCUM, FINAL, DONE.
- IDLE: start=1 → latch mode, bias; acc ← sign_ext(bias) << BIAS_SHIFT (modes 0/2/3) or −2^(DATA_W−1) (mode 1); sat flag cleared; → ACCUM.
- ACCUM: beat accepted when in_valid && in_ready.
  - Modes 0/2/3: acc ← sat_ACC_W(acc + in_data×in_weight), full-precision signed product. On clamp to ±limit, set sat flag (sticky).
  - Mode 1: acc ← max(acc, sign_ext(in_data)), signed compare.
  - Accepted beat with in_last=1 → FINAL. A job has ≥1 beat; no zero-length jobs.
- FINAL (one cycle): s = acc >>> OUT_SHIFT (floor).
  - Mode 0/3: s<0 → 0 (no flag); s > 2^(DATA_W−1)−1 → clamp, set sat.
  - Mode 2: clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1], set sat on clamp.
  - Mode 1: out_result = acc[DATA_W−1:0], sat stays 0.
  - Register out_result/out_sat → DONE.
- DONE: out_valid=1, out_result/out_sat held stable; out_ready=1 → IDLE.
- start outside IDLE ignored; in_valid outside ACCUM ignored (in_ready=0).
- Reset (any state): state IDLE, acc 0, busy 0, in_ready 0, out_valid 0, out_result 0, out_sat 0. Partial job discarded.

## Timing
- start at edge t (IDLE) → busy and in_ready high from t+1.
- Throughput 1 beat/cycle in ACCUM; gaps via in_valid low allowed indefinitely.
- in_last accepted at edge t → FINAL during t+1 (in_ready 0) → out_valid high from t+2.
- Handshake completes at the edge where out_valid && out_ready; IDLE next cycle; new start accepted in that IDLE cycle at the earliest (one bubble per job).
- out_ready low: DONE held, outputs unchanged, no back-to-back start accepted.
- Outputs registered; no combinational in→out paths except none (in_ready, busy, out_valid decode from state register).

## Test plan
- Mode 0, bias=2, beats (3,4),(−2,5,last): acc=32+12−10=34, >>>4=2 → out_result=2, out_sat=0, out_valid 2 cycles after last beat.
- Mode 0, bias=0, single beat (−8,8): −64>>>4=−4 → 0, out_sat=0; mode 2 same stimulus → −4 (0xFC), out_sat=0.
- Mode 0, bias=0, 16 beats (127,127): acc=258064, >>>4=16129 → 127, out_sat=1; mode 2, single beat (−128,127) → −128, out_sat=1.
- Accumulator saturation: mode 2, 512 beats (−128,−128) → acc clamps at 8388607, out_result=127, out_sat=1.
- Mode 1, data 5,−3,100,−128(last), weights random → 100; all-negative stream −7,−2,−9 → −2; out_sat=0.
- Protocol: start while busy ignored; in_valid gaps in ACCUM; out_ready low 5 cycles holds result; rst_n low mid-ACCUM → all outputs 0 immediately, next job result unaffected by discarded beats.
